// File: rtl/axis_latency_pipe.sv
// axis_latency_pipe: AXI-Stream delay line that stamps ingress time and pipe latency into tuser (macro: LATENCY_STATS_EN).
// Latency: DEPTH cycles when unstalled, 0 in bypass mode; throughput is 1 beat/cycle.
// Backpressure: per-stage valid/ready where bubbles collapse; i_tready falls only when every stage holds a stalled beat.
module axis_latency_pipe #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 32,
  parameter int TS_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             cfg_bypass,
  input  logic [63:0]      timer,
  input  logic [63:0]      header,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [127:0]     o_tuser,
  output logic [31:0]      pkt_count,
  output logic [31:0]      max_latency,
  output logic             busy
);

  // Stage storage: valids are reset, payload registers are not.
  logic [DEPTH-1:0]    stg_vld;
  logic [DEPTH-1:0]    stg_rdy;
  logic [DEPTH-1:0]    stg_last;
  logic [WIDTH-1:0]    stg_dat [DEPTH];
  logic [TS_WIDTH-1:0] stg_ts  [DEPTH];

  logic                rdy_acc;
  logic                bypass_mode;
  logic                sof;
  logic [TS_WIDTH-1:0] ts_hold;
  logic [TS_WIDTH-1:0] ts_now;
  logic [TS_WIDTH-1:0] ts_in;
  logic [TS_WIDTH-1:0] ts_out;
  logic [TS_WIDTH-1:0] lat_out;
  logic                in_hs;
  logic                out_hs;
  logic                unused_timer_hi;

  assign ts_now          = timer[TS_WIDTH-1:0];
  assign unused_timer_hi = ^timer[63:TS_WIDTH];

  // Head beat takes the live timer; later beats of the packet reuse the held head stamp.
  assign ts_in  = sof ? ts_now : ts_hold;
  assign in_hs  = i_tvalid & i_tready;
  assign out_hs = o_tvalid & o_tready;
  assign busy   = |stg_vld;

  // Ready chain, unrolled: stage k may advance if any stage at or after k is empty, or the sink accepts.
  always_comb begin
    stg_rdy = '0;
    rdy_acc = o_tready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_acc    = rdy_acc | ~stg_vld[k];
      stg_rdy[k] = rdy_acc;
    end
  end

  // Stage valid bits; stage 0 never loads while bypassing so the pipe stays empty in that mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_vld <= '0;
    end else begin
      if (stg_rdy[0]) stg_vld[0] <= i_tvalid & ~bypass_mode;
      for (int k = 1; k < DEPTH; k++) begin
        if (stg_rdy[k]) stg_vld[k] <= stg_vld[k-1];
      end
    end
  end

  // Stage payload shifts alongside the valid bits whenever the stage is ready.
  always_ff @(posedge clk) begin
    if (stg_rdy[0]) begin
      stg_dat[0]  <= i_tdata;
      stg_last[0] <= i_tlast;
      stg_ts[0]   <= ts_in;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (stg_rdy[k]) begin
        stg_dat[k]  <= stg_dat[k-1];
        stg_last[k] <= stg_last[k-1];
        stg_ts[k]   <= stg_ts[k-1];
      end
    end
  end

  // Mode switch only when the pipe is empty and no beat is entering, so no beat straddles both paths.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bypass_mode <= 1'b0;
      sof         <= 1'b1;
      ts_hold     <= '0;
    end else begin
      if (!busy && !in_hs) bypass_mode <= cfg_bypass;
      if (in_hs) begin
        sof <= i_tlast;
        if (sof) ts_hold <= ts_now;
      end
    end
  end

  // Output mux: pipe tail in normal mode, straight wire-through in bypass.
  always_comb begin
    if (bypass_mode) begin
      i_tready = o_tready;
      o_tvalid = i_tvalid;
      o_tdata  = i_tdata;
      o_tlast  = i_tlast;
      ts_out   = ts_now;
      lat_out  = '0;
    end else begin
      i_tready = stg_rdy[0];
      o_tvalid = stg_vld[DEPTH-1];
      o_tdata  = stg_dat[DEPTH-1];
      o_tlast  = stg_last[DEPTH-1];
      ts_out   = stg_ts[DEPTH-1];
      // Modular subtraction keeps the result correct across a timer wrap.
      lat_out  = ts_now - stg_ts[DEPTH-1];
    end
  end

  assign o_tuser = {header, 32'(ts_out), 32'(lat_out)};

  // Delivered-packet counter; clear beats a same-cycle increment, natural 32-bit wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= 32'h0;
    end else if (clear) begin
      pkt_count <= 32'h0;
    end else if (out_hs && o_tlast) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

`ifdef LATENCY_STATS_EN
  logic        osof;
  logic [31:0] lat_ext;

  assign lat_ext = 32'(lat_out);

  // Track worst head-beat latency; osof marks the next output beat as a packet head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      osof        <= 1'b1;
      max_latency <= 32'h0;
    end else begin
      if (out_hs) osof <= o_tlast;
      if (clear) begin
        max_latency <= 32'h0;
      end else if (out_hs && osof && (lat_ext > max_latency)) begin
        max_latency <= lat_ext;
      end
    end
  end
`else
  assign max_latency = 32'h0;
`endif

endmodule

// File: tb/tb_axis_latency_pipe.sv
// tb_axis_latency_pipe: directed bench for axis_latency_pipe (DEPTH=4, WIDTH=32, TS_WIDTH=32).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// A scoreboard checks every delivered beat against the accepted input stream.
module tb_axis_latency_pipe;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int TS_WIDTH = 32;
`ifdef LATENCY_STATS_EN
  localparam logic [31:0] EXP_MAX = 32'd14;
`else
  localparam logic [31:0] EXP_MAX = 32'd0;
`endif

  logic             clk = 1'b0;
  logic             reset_n, clear, cfg_bypass;
  logic [63:0]      timer, header, timer_base;
  logic [63:0]      cyc = 64'd0;
  logic [WIDTH-1:0] i_tdata, o_tdata;
  logic             i_tlast, i_tvalid, i_tready;
  logic             o_tlast, o_tvalid, o_tready;
  logic [127:0]     o_tuser;
  logic [31:0]      pkt_count, max_latency;
  logic             busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;
  assign timer = timer_base + cyc;

  axis_latency_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TS_WIDTH(TS_WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .cfg_bypass(cfg_bypass),
    .timer(timer), .header(header),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tuser(o_tuser), .pkt_count(pkt_count), .max_latency(max_latency), .busy(busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Scoreboard: accepted beats queue up, delivered beats must match in order.
  logic [WIDTH:0] exp_q[$];
  int             mdl_pkts = 0;
  logic           last_in_hs = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      mdl_pkts   = 0;
      last_in_hs = 1'b0;
    end else begin
      last_in_hs = i_tvalid && i_tready;
      if (last_in_hs) exp_q.push_back({i_tlast, i_tdata});
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_beat: got 0x%0h, required no beat", o_tdata);
        end else begin
          chk("stream_order", {o_tlast, o_tdata}, exp_q.pop_front());
        end
        if (o_tlast) mdl_pkts++;
      end
      if (clear) mdl_pkts = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    chk({name, "_drained"}, busy, 1'b0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic clear_pulse();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  typedef struct {
    logic        ivld;
    logic [31:0] idat;
    logic        ilast;
    logic        ordy;
    logic        ovld;
    logic [31:0] odat;
    logic        olast;
    logic        irdy;
    logic [31:0] olat;
  } vec_t;

  vec_t vt[12];
  int   idx, sent, tl, guard, xs[4];
  logic seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Per-cycle vectors for an 8-beat packet through a 4-stage pipe with the timer zeroed at row 0.
    vt[0]  = '{1'b1, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0};
    vt[1]  = '{1'b1, 32'h2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0};
    vt[2]  = '{1'b1, 32'h3, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0};
    vt[3]  = '{1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0};
    vt[4]  = '{1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 1'b1, 32'd4};
    vt[5]  = '{1'b1, 32'h6, 1'b0, 1'b1, 1'b1, 32'h2, 1'b0, 1'b1, 32'd5};
    vt[6]  = '{1'b1, 32'h7, 1'b0, 1'b1, 1'b1, 32'h3, 1'b0, 1'b1, 32'd6};
    vt[7]  = '{1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 32'd7};
    vt[8]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h5, 1'b0, 1'b1, 32'd8};
    vt[9]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h6, 1'b0, 1'b1, 32'd9};
    vt[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h7, 1'b0, 1'b1, 32'd10};
    vt[11] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 32'd11};

    reset_n = 1'b0; clear = 1'b0; cfg_bypass = 1'b0;
    header = 64'hC0DE_0000_1234_5678; timer_base = 64'd0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;

    // Reset state
    #3;
    chk("rst_i_tready", i_tready, 1'b1);
    chk("rst_o_tvalid", o_tvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_max_latency", max_latency, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 8-beat packet, per-cycle table
    for (int n = 0; n < 12; n++) begin
      tick();
      if (n == 0) timer_base = 64'd0 - cyc;
      i_tvalid = vt[n].ivld; i_tdata = vt[n].idat; i_tlast = vt[n].ilast; o_tready = vt[n].ordy;
      @(negedge clk);
      chk($sformatf("t1_row%0d_o_tvalid", n), o_tvalid, vt[n].ovld);
      chk($sformatf("t1_row%0d_i_tready", n), i_tready, vt[n].irdy);
      if (vt[n].ovld) begin
        chk($sformatf("t1_row%0d_o_tdata", n), o_tdata, vt[n].odat);
        chk($sformatf("t1_row%0d_o_tlast", n), o_tlast, vt[n].olast);
        chk($sformatf("t1_row%0d_latency", n), o_tuser[31:0], vt[n].olat);
        chk($sformatf("t1_row%0d_ingress", n), o_tuser[63:32], 32'd0);
        chk($sformatf("t1_row%0d_header", n), o_tuser[127:64], 64'hC0DE_0000_1234_5678);
      end
    end
    tick();
    drain("t1");

    // Timer wrap: head stamped at 0xFFFFFFFE still reports a latency of DEPTH
    tick();
    timer_base = 64'h0000_0000_FFFF_FFFE - cyc;
    i_tvalid = 1'b1; i_tdata = 32'hBEEF; i_tlast = 1'b1; o_tready = 1'b1;
    tick();
    i_tvalid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_tvalid) seen = 1'b1;
    end
    chk("wrap_seen", seen, 1'b1);
    chk("wrap_latency", o_tuser[31:0], 32'd4);
    chk("wrap_ingress", o_tuser[63:32], 32'hFFFF_FFFE);
    tick();
    drain("wrap");

    // Stall: sink blocked, exactly DEPTH beats fit, then release with no loss
    o_tready = 1'b0; idx = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (i_tvalid && last_in_hs) idx++;
      i_tvalid = 1'b1; i_tdata = 32'h100 + idx; i_tlast = (idx == 7);
    end
    tick();
    if (i_tvalid && last_in_hs) idx++;
    chk("stall_accepted", idx, DEPTH);
    @(negedge clk);
    chk("stall_i_tready", i_tready, 1'b0);
    chk("stall_busy", busy, 1'b1);
    chk("stall_head", {o_tvalid, o_tdata}, {1'b1, 32'h100});
    guard = 0;
    while (idx < 8 && guard < 100) begin
      tick();
      guard++;
      if (i_tvalid && last_in_hs) idx++;
      o_tready = 1'b1;
      if (idx < 8) begin
        i_tvalid = 1'b1; i_tdata = 32'h100 + idx; i_tlast = (idx == 7);
      end else begin
        i_tvalid = 1'b0;
      end
    end
    chk("stall_all_sent", idx, 8);
    drain("stall");
    chk("pkt_count_before_clear", pkt_count, 32'd3);
    chk("pkt_count_model", pkt_count, mdl_pkts);

    // Random valid/ready, 1000 beats
    clear_pulse();
    chk("clear_pkt_count", pkt_count, 32'd0);
    sent = 0; tl = 0; guard = 0;
    while ((sent < 1000 || busy) && guard < 20000) begin
      tick();
      guard++;
      if (i_tvalid && last_in_hs) begin
        sent++;
        if (i_tlast) tl++;
        i_tvalid = 1'b0;
      end
      if (!i_tvalid && sent < 1000 && $urandom_range(1, 0) == 1) begin
        i_tvalid = 1'b1;
        i_tdata  = $urandom;
        i_tlast  = (sent == 999) || ($urandom_range(7, 0) == 0);
      end
      o_tready = ($urandom_range(1, 0) == 1);
    end
    chk("rand_beats_sent", sent, 1000);
    drain("rand");
    chk("rand_pkt_count", pkt_count, tl);

    // Bypass requested mid-packet: takes effect only once the pipe has drained
    tick();
    o_tready = 1'b1;
    i_tvalid = 1'b1; i_tdata = 32'hA0; i_tlast = 1'b0;
    timer_base = 64'd0 - cyc;
    tick(); i_tdata = 32'hA1;
    tick(); i_tdata = 32'hA2; cfg_bypass = 1'b1;
    @(negedge clk);
    chk("byp_busy_hold", busy, 1'b1);
    chk("byp_not_yet", o_tvalid, 1'b0);
    tick(); i_tdata = 32'hA3; i_tlast = 1'b1;
    tick(); i_tvalid = 1'b0;
    @(negedge clk);
    chk("byp_pipe_head", {o_tvalid, o_tdata}, {1'b1, 32'hA0});
    chk("byp_pipe_latency", o_tuser[31:0], 32'd4);
    guard = 0;
    while (busy && guard < 20) begin
      tick();
      guard++;
    end
    chk("byp_drained", busy, 1'b0);
    tick();
    i_tvalid = 1'b1; i_tdata = 32'hB0; i_tlast = 1'b1; o_tready = 1'b1;
    @(negedge clk);
    chk("byp_same_cycle", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b1, 32'hB0});
    chk("byp_latency", o_tuser[31:0], 32'd0);
    chk("byp_ingress", o_tuser[63:32], timer[31:0]);
    chk("byp_header", o_tuser[127:64], 64'hC0DE_0000_1234_5678);
    chk("byp_busy", busy, 1'b0);
    tick();
    i_tdata = 32'hB1; o_tready = 1'b0;
    @(negedge clk);
    chk("byp_i_tready", i_tready, 1'b0);
    tick();
    o_tready = 1'b1;
    tick();
    i_tvalid = 1'b0; cfg_bypass = 1'b0;
    tick();
    i_tvalid = 1'b1; i_tdata = 32'hC0; i_tlast = 1'b1;
    @(negedge clk);
    chk("byp_back_to_pipe", o_tvalid, 1'b0);
    tick();
    drain("byp");

    // Latency stats: head beats stalled 4, 10, 6 extra cycles; a 4th with clear on its delivery cycle
    clear_pulse();
    xs[0] = 4; xs[1] = 10; xs[2] = 6; xs[3] = 2;
    for (int p = 0; p < 4; p++) begin
      if (p == 3) begin
        chk("stats_max", max_latency, EXP_MAX);
        chk("stats_pkt_count", pkt_count, 32'd3);
      end
      tick();
      i_tvalid = 1'b1; i_tdata = 32'h600 + xs[p]; i_tlast = 1'b1; o_tready = 1'b0;
      for (int k = 0; k < 3 + xs[p]; k++) begin
        tick();
        i_tvalid = 1'b0;
      end
      tick();
      o_tready = 1'b1;
      if (p == 3) clear = 1'b1;
      @(negedge clk);
      chk($sformatf("stats_p%0d_out", p), {o_tvalid, o_tdata}, {1'b1, 32'h600 + xs[p]});
      chk($sformatf("stats_p%0d_latency", p), o_tuser[31:0], DEPTH + xs[p]);
      tick();
      clear = 1'b0;
    end
    chk("stats_clear_max", max_latency, 32'd0);
    chk("stats_clear_pkt_count", pkt_count, 32'd0);

    // Reset in the middle of a packet flushes the stages
    o_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_tvalid = 1'b1; i_tdata = 32'h700 + k; i_tlast = 1'b0;
      tick();
    end
    i_tvalid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_o_tvalid", o_tvalid, 1'b0);
    chk("midrst_i_tready", i_tready, 1'b1);
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    tick();
    i_tvalid = 1'b1; i_tdata = 32'h7FF; i_tlast = 1'b1; o_tready = 1'b1;
    tick();
    drain("midrst");
    chk("midrst_pkt_count", pkt_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
